// File: rtl/tms_pwr_pkg.sv
// rtl/tms_pwr_pkg.sv - shared types and constants for the power-stage sequencers
// Purpose: sequencer state encoding, device counts and default us prescale.
// Ports: none (package).
package tms_pwr_pkg;

  localparam int N_IGBT         = 5;
  localparam int N_SCR          = 2;
  localparam int CLK_PER_US_DEF = 50;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCR_FIRE = 3'd1,
    S_DEAD     = 3'd2,
    S_IGBT_ON  = 3'd3,
    S_IGBT_OFF = 3'd4,
    S_DONE     = 3'd5
  } seq_state_t;

endpackage

// File: rtl/igbt_scr_pulse_seq_if.sv
// rtl/igbt_scr_pulse_seq_if.sv - command/status bundle of the IGBT/SCR pulse sequencer
// Purpose: groups the host command inputs and the driver/status outputs.
// Ports (modport slave = sequencer side):
//   in : start, abort, igbt_mask, scr_mask, on_time_us, off_time_us, pulse_num
//   out: IGBT_on_EN, SCR_on_EN, busy, done, start_err, pulse_cnt
interface igbt_scr_pulse_seq_if
  import tms_pwr_pkg::*;
#(
  parameter int TIME_W = 16,
  parameter int CNT_W  = 12
);

  logic              start;
  logic              abort;
  logic [N_IGBT-1:0] igbt_mask;
  logic [N_SCR-1:0]  scr_mask;
  logic [TIME_W-1:0] on_time_us;
  logic [TIME_W-1:0] off_time_us;
  logic [CNT_W-1:0]  pulse_num;
  logic [N_IGBT-1:0] IGBT_on_EN;
  logic [N_SCR-1:0]  SCR_on_EN;
  logic              busy;
  logic              done;
  logic              start_err;
  logic [CNT_W-1:0]  pulse_cnt;

  modport master (
    output start, abort, igbt_mask, scr_mask, on_time_us, off_time_us, pulse_num,
    input  IGBT_on_EN, SCR_on_EN, busy, done, start_err, pulse_cnt
  );

  modport slave (
    input  start, abort, igbt_mask, scr_mask, on_time_us, off_time_us, pulse_num,
    output IGBT_on_EN, SCR_on_EN, busy, done, start_err, pulse_cnt
  );

endinterface

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - microsecond prescaler with synchronous clear
// Purpose: counts 0..CLK_PER_US-1 and flags the last count as a 1-cycle tick.
// Ports: sys_clk, sys_rst (sync, active-high), clr (restart at 0), tick (out).
module us_tick_gen #(
  parameter int CLK_PER_US = 50
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_US - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      presc <= '0;
    end else if (presc == LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == LAST);

endmodule

// File: rtl/igbt_scr_pulse_seq.sv
// rtl/igbt_scr_pulse_seq.sv - timed SCR pre-fire / IGBT pulse train sequencer
// Purpose: runs one train per accepted start: SCR fire, dead time, N IGBT pulses.
// Ports: sys_clk, sys_rst (sync, active-high), bus (igbt_scr_pulse_seq_if.slave).
module igbt_scr_pulse_seq
  import tms_pwr_pkg::*;
#(
  parameter int CLK_PER_US   = CLK_PER_US_DEF,
  parameter int TIME_W       = 16,
  parameter int CNT_W        = 12,
  parameter int SCR_PULSE_US = 10,
  parameter int DEAD_US      = 2
) (
  input logic                 sys_clk,
  input logic                 sys_rst,
  igbt_scr_pulse_seq_if.slave bus
);

  localparam int PH_W = TIME_W + 1;

  seq_state_t state, state_n;

  logic              tick;
  logic [PH_W-1:0]   ph_cnt, ph_val;
  logic              ph_load, ph_end;
  logic              latch, cnt_clr, cnt_inc, err_n;
  logic [N_IGBT-1:0] igbt_q, igbt_n;
  logic [N_SCR-1:0]  scr_q, scr_n;
  logic [TIME_W-1:0] on_q, off_q;
  logic [CNT_W-1:0]  pnum_q;
  logic              start_ok;

  // Prescaler is held at 0 in IDLE so every phase starts on a us boundary.
  us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (state == S_IDLE),
    .tick    (tick)
  );

  assign ph_end   = tick && (ph_cnt == PH_W'(1));
  assign start_ok = (bus.igbt_mask != '0) && (bus.on_time_us != '0) && (bus.pulse_num != '0);
  assign igbt_n   = latch ? bus.igbt_mask : igbt_q;
  assign scr_n    = latch ? bus.scr_mask  : scr_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    ph_load = 1'b0;
    ph_val  = '0;
    latch   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (!start_ok) begin
            err_n = 1'b1;
          end else begin
            latch   = 1'b1;
            cnt_clr = 1'b1;
            ph_load = 1'b1;
            if (bus.scr_mask != '0) begin
              state_n = S_SCR_FIRE;
              ph_val  = PH_W'(SCR_PULSE_US);
            end else begin
              state_n = S_IGBT_ON;
              ph_val  = {1'b0, bus.on_time_us};
              cnt_inc = 1'b1;
            end
          end
        end
      end
      S_SCR_FIRE: if (ph_end) begin
        state_n = S_DEAD;
        ph_load = 1'b1;
        ph_val  = PH_W'(DEAD_US);
      end
      S_DEAD: if (ph_end) begin
        state_n = S_IGBT_ON;
        ph_load = 1'b1;
        ph_val  = {1'b0, on_q};
        cnt_inc = 1'b1;
      end
      S_IGBT_ON: if (ph_end) begin
        if (bus.pulse_cnt < pnum_q) begin
          state_n = S_IGBT_OFF;
          ph_load = 1'b1;
          ph_val  = (off_q == '0) ? PH_W'(1) : {1'b0, off_q};
        end else begin
          state_n = S_DONE;
        end
      end
      S_IGBT_OFF: if (ph_end) begin
        state_n = S_IGBT_ON;
        ph_load = 1'b1;
        ph_val  = {1'b0, on_q};
        cnt_inc = 1'b1;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Abort overrides everything, including a same-cycle start.
    if (bus.abort) begin
      state_n = S_IDLE;
      ph_load = 1'b0;
      latch   = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      err_n   = 1'b0;
    end
  end

  // Outputs are registered from the next state so the first enable appears
  // on the cycle after the accepted start.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      igbt_q         <= '0;
      scr_q          <= '0;
      on_q           <= '0;
      off_q          <= '0;
      pnum_q         <= '0;
      ph_cnt         <= '0;
      bus.pulse_cnt  <= '0;
      bus.IGBT_on_EN <= '0;
      bus.SCR_on_EN  <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.start_err  <= 1'b0;
    end else begin
      if (latch) begin
        igbt_q <= bus.igbt_mask;
        scr_q  <= bus.scr_mask;
        on_q   <= bus.on_time_us;
        off_q  <= bus.off_time_us;
        pnum_q <= bus.pulse_num;
      end
      if (ph_load)                    ph_cnt <= ph_val;
      else if (tick && ph_cnt != '0)  ph_cnt <= ph_cnt - 1'b1;
      if (cnt_clr)      bus.pulse_cnt <= cnt_inc ? CNT_W'(1) : '0;
      else if (cnt_inc) bus.pulse_cnt <= bus.pulse_cnt + 1'b1;
      bus.IGBT_on_EN <= (state_n == S_IGBT_ON)  ? igbt_n : '0;
      bus.SCR_on_EN  <= (state_n == S_SCR_FIRE) ? scr_n  : '0;
      bus.busy       <= (state_n != S_IDLE);
      bus.done       <= (state_n == S_DONE);
      bus.start_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_igbt_scr_pulse_seq.sv
// tb/tb_igbt_scr_pulse_seq.sv - directed self-checking bench for igbt_scr_pulse_seq
module tb_igbt_scr_pulse_seq;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #10 sys_clk = ~sys_clk;

  igbt_scr_pulse_seq_if bus_if ();

  igbt_scr_pulse_seq dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Per-train observations, counted in cycles after the start cycle.
  int rise [8];
  int fall [8];
  int nr, nf, igbt_cyc, scr_cyc, first_scr, done_at, done_n, err_n, idle_at;
  logic [4:0] igbt_val;
  logic [1:0] scr_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Interlock: SCR and IGBT enables are never simultaneously non-zero.
  always @(negedge sys_clk) begin
    n_checks++;
    assert (!((|bus_if.SCR_on_EN) && (|bus_if.IGBT_on_EN))) else begin
      n_fail++;
      $error("FAIL interlock observed scr=%0d igbt=%0d expected one zero",
             bus_if.SCR_on_EN, bus_if.IGBT_on_EN);
    end
  end

  // Drive a one-cycle start; returns at the negedge of cycle 1 after start.
  task automatic do_start(input logic [1:0] scr, input logic [4:0] igbt,
                          input int on_us, input int off_us, input int pn);
    bus_if.scr_mask    = scr;
    bus_if.igbt_mask   = igbt;
    bus_if.on_time_us  = 16'(on_us);
    bus_if.off_time_us = 16'(off_us);
    bus_if.pulse_num   = 12'(pn);
    bus_if.start       = 1'b1;
    @(negedge sys_clk);
    bus_if.start       = 1'b0;
  endtask

  // Observe from the current negedge until busy drops or maxc cycles pass.
  task automatic watch(input int maxc);
    logic prev_i;
    prev_i = 1'b0;
    nr = 0; nf = 0; igbt_cyc = 0; scr_cyc = 0; first_scr = 0;
    done_at = 0; done_n = 0; err_n = 0; idle_at = 0; igbt_val = '0; scr_val = '0;
    for (int c = 1; c <= maxc; c++) begin
      if ((|bus_if.IGBT_on_EN) && !prev_i && nr < 8) begin rise[nr] = c; nr++; end
      if (!(|bus_if.IGBT_on_EN) && prev_i && nf < 8) begin fall[nf] = c; nf++; end
      if (|bus_if.IGBT_on_EN) begin
        igbt_cyc++;
        if (igbt_val == '0) igbt_val = bus_if.IGBT_on_EN;
      end
      if (|bus_if.SCR_on_EN) begin
        scr_cyc++;
        if (first_scr == 0) begin first_scr = c; scr_val = bus_if.SCR_on_EN; end
      end
      if (bus_if.done) begin done_n++; if (done_at == 0) done_at = c; end
      if (bus_if.start_err) err_n++;
      if (!bus_if.busy) begin idle_at = c; break; end
      prev_i = |bus_if.IGBT_on_EN;
      @(negedge sys_clk);
    end
    chk("watch_finished", 32'(idle_at != 0), 32'd1);
  endtask

  initial begin
    bus_if.start = 1'b0; bus_if.abort = 1'b0;
    bus_if.igbt_mask = '0; bus_if.scr_mask = '0;
    bus_if.on_time_us = '0; bus_if.off_time_us = '0; bus_if.pulse_num = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_igbt", 32'(bus_if.IGBT_on_EN), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_cnt",  32'(bus_if.pulse_cnt), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Single pulse: 3 us on, no SCR.
    do_start(2'b00, 5'b00001, 3, 0, 1);
    watch(400);
    chk("sp_rise",   32'(rise[0]), 32'd1);
    chk("sp_len",    32'(igbt_cyc), 32'd150);
    chk("sp_mask",   32'(igbt_val), 32'd1);
    chk("sp_done",   32'(done_at), 32'd151);
    chk("sp_done_n", 32'(done_n), 32'd1);
    chk("sp_idle",   32'(idle_at), 32'd152);
    chk("sp_cnt",    32'(bus_if.pulse_cnt), 32'd1);
    chk("sp_scr",    32'(scr_cyc), 32'd0);

    // Full train: SCR 10 us, dead 2 us, three 2 us on / 4 us off pulses.
    do_start(2'b01, 5'b11111, 2, 4, 3);
    watch(2000);
    chk("ft_scr_first", 32'(first_scr), 32'd1);
    chk("ft_scr_val",   32'(scr_val), 32'd1);
    chk("ft_scr_len",   32'(scr_cyc), 32'd500);
    chk("ft_rise0",     32'(rise[0]), 32'd601);
    chk("ft_fall0",     32'(fall[0]), 32'd701);
    chk("ft_rise1",     32'(rise[1]), 32'd901);
    chk("ft_rise2",     32'(rise[2]), 32'd1201);
    chk("ft_npulse",    32'(nr), 32'd3);
    chk("ft_igbt_len",  32'(igbt_cyc), 32'd300);
    chk("ft_igbt_val",  32'(igbt_val), 32'd31);
    chk("ft_done",      32'(done_at), 32'd1301);
    chk("ft_cnt",       32'(bus_if.pulse_cnt), 32'd3);

    // Rejected starts: zero igbt mask, zero on time, zero pulse count.
    for (int k = 0; k < 3; k++) begin
      do_start(2'b01, (k == 0) ? 5'b00000 : 5'b00100, (k == 1) ? 0 : 2, 1, (k == 2) ? 0 : 2);
      chk("rej_err",  32'(bus_if.start_err), 32'd1);
      chk("rej_busy", 32'(bus_if.busy), 32'd0);
      chk("rej_en",   32'({bus_if.SCR_on_EN, bus_if.IGBT_on_EN}), 32'd0);
      @(negedge sys_clk);
      chk("rej_err_pulse", 32'(bus_if.start_err), 32'd0);
      chk("rej_busy2",     32'(bus_if.busy), 32'd0);
    end

    // off_time 0 is treated as 1 us.
    do_start(2'b00, 5'b00010, 1, 0, 2);
    watch(400);
    chk("off0_gap",  32'(rise[1] - fall[0]), 32'd50);
    chk("off0_done", 32'(done_at), 32'd151);

    // Abort during the second IGBT_ON of a 5-pulse train.
    do_start(2'b00, 5'b01000, 1, 1, 5);
    repeat (119) @(negedge sys_clk);
    chk("ab_pre_on", 32'(bus_if.IGBT_on_EN), 32'd8);
    bus_if.abort = 1'b1;
    @(negedge sys_clk);
    bus_if.abort = 1'b0;
    chk("ab_en",   32'({bus_if.SCR_on_EN, bus_if.IGBT_on_EN}), 32'd0);
    chk("ab_busy", 32'(bus_if.busy), 32'd0);
    chk("ab_cnt",  32'(bus_if.pulse_cnt), 32'd2);
    done_n = 0;
    repeat (300) begin
      if (bus_if.done || bus_if.busy) done_n++;
      @(negedge sys_clk);
    end
    chk("ab_quiet", 32'(done_n), 32'd0);

    // Start while busy is ignored; the original train runs to completion.
    do_start(2'b00, 5'b00001, 3, 0, 1);
    repeat (9) @(negedge sys_clk);
    do_start(2'b00, 5'b11110, 1, 0, 1);
    watch(400);
    chk("sb_mask", 32'(igbt_val), 32'd1);
    chk("sb_len",  32'(igbt_cyc), 32'd140);
    chk("sb_done", 32'(done_at), 32'd141);
    chk("sb_err",  32'(err_n), 32'd0);

    // Abort and start together in IDLE: nothing happens.
    bus_if.abort = 1'b1;
    do_start(2'b01, 5'b00001, 1, 1, 1);
    bus_if.abort = 1'b0;
    chk("as_busy", 32'(bus_if.busy), 32'd0);
    chk("as_err",  32'(bus_if.start_err), 32'd0);
    chk("as_en",   32'({bus_if.SCR_on_EN, bus_if.IGBT_on_EN}), 32'd0);
    repeat (5) @(negedge sys_clk);
    chk("as_busy2", 32'(bus_if.busy), 32'd0);

    // Reset in the middle of SCR_FIRE.
    do_start(2'b10, 5'b00001, 1, 1, 1);
    repeat (49) @(negedge sys_clk);
    chk("rs_scr_on", 32'(bus_if.SCR_on_EN), 32'd2);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("rs_en",   32'({bus_if.SCR_on_EN, bus_if.IGBT_on_EN}), 32'd0);
    chk("rs_busy", 32'(bus_if.busy), 32'd0);
    chk("rs_stat", 32'({bus_if.done, bus_if.start_err}), 32'd0);
    chk("rs_cnt",  32'(bus_if.pulse_cnt), 32'd0);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rs_stay_idle", 32'(bus_if.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
